// File: rtl/uart_port.sv
// 8N1 UART with independent transmitter and receiver plus a receive buffer.
// Define UART_RX_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register.
module uart_port #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       uart0_busy,
  output logic       uart0_overrun,
  output logic       uart0_ferr,
  output logic       tx,
  input  logic       rx
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      tx         <= 1'b1;
      uart0_busy <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (uart0_wr) begin
            tx_sh      <= uart_w;
            tx         <= 1'b0;
            uart0_busy <= 1'b1;
            tx_cnt     <= BIT_LAST;
            tx_state   <= START;
          end
        end
        START: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx       <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= 3'd0;
            tx_cnt   <= BIT_LAST;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx     <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            uart0_busy <= 1'b0;
            tx_state   <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  // rx_d is a delayed copy of the synchronised line, used only for falling-edge detection.
  state_t      rx_state;
  logic        rx_s1, rx_s2, rx_d;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_brk;
  logic        rx_done;
  logic        rx_store;

  assign rx_done  = (rx_state == STOP) && !rx_brk && (rx_cnt == 16'd0);
  assign rx_store = rx_done && rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_brk     <= 1'b0;
      uart0_ferr <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      uart0_ferr <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (!rx_s2 && rx_d) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_s2) begin
            rx_state <= IDLE;
          end else begin
            rx_bit   <= 3'd0;
            rx_cnt   <= BIT_LAST;
            rx_state <= DATA;
          end
        end
        DATA: begin
          if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= BIT_LAST;
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end
        end
        STOP: begin
          // rx_brk holds here after a framing error until the line returns high
          if (rx_brk) begin
            if (rx_s2) begin
              rx_brk   <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
          end else if (rx_s2) begin
            rx_state <= IDLE;
          end else begin
            rx_brk     <= 1'b1;
            uart0_ferr <= 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // ---------------- receive buffer ----------------
`ifdef UART_RX_FIFO_EN
  logic [7:0] rx_mem [4];
  logic [1:0] rd_ptr, wr_ptr, rd_ptr_nx;
  logic [2:0] count, count_nx, left;
  logic       pop, push;
  logic [7:0] head_nx;

  always_comb begin
    pop       = uart0_rd && (count != 3'd0);
    push      = rx_store && ((count != 3'd4) || pop);
    rd_ptr_nx = rd_ptr + {1'b0, pop};
    left      = count - {2'b00, pop};
    count_nx  = left + {2'b00, push};
    // an empty-after-pop FIFO takes its new head straight from the receiver
    head_nx   = (left == 3'd0) ? rx_sh : rx_mem[rd_ptr_nx];
  end

  always_ff @(posedge clk) begin
    if (push) rx_mem[wr_ptr] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      uart0_valid   <= 1'b0;
      uart0_data    <= '0;
      uart0_overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      rd_ptr      <= rd_ptr_nx;
      count       <= count_nx;
      uart0_valid <= (count_nx != 3'd0);
      if (count_nx != 3'd0) uart0_data <= head_nx;
      if (uart0_rd)                uart0_overrun <= 1'b0;
      else if (rx_store && !push)  uart0_overrun <= 1'b1;
    end
  end
`else
  logic pop;
  assign pop = uart0_rd && uart0_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      uart0_valid   <= 1'b0;
      uart0_data    <= '0;
      uart0_overrun <= 1'b0;
    end else begin
      if (rx_store && (!uart0_valid || pop)) begin
        uart0_data  <= rx_sh;
        uart0_valid <= 1'b1;
      end else if (pop) begin
        uart0_valid <= 1'b0;
      end
      if (uart0_rd)                     uart0_overrun <= 1'b0;
      else if (rx_store && uart0_valid) uart0_overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_port.sv
// Randomised and directed bench for uart_port against a frame-level reference model.
module tb_uart_port;
  localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  // line change to stored byte: 2 sync flops + edge detect, half bit, 9 bits
  localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart0_wr = 1'b0;
  logic [7:0] uart_w = 8'h00;
  logic       uart0_rd = 1'b0;
  logic       uart0_valid;
  logic [7:0] uart0_data;
  logic       uart0_busy;
  logic       uart0_overrun;
  logic       uart0_ferr;
  logic       tx;
  logic       rx = 1'b1;

  uart_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .uart0_wr(uart0_wr), .uart_w(uart_w), .uart0_rd(uart0_rd),
    .uart0_valid(uart0_valid), .uart0_data(uart0_data), .uart0_busy(uart0_busy),
    .uart0_overrun(uart0_overrun), .uart0_ferr(uart0_ferr), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    logic [7:0] b;
    logic       stop;
  } rxev_t;

  int         cyc = 0;
  bit         m_init = 0;
  logic       m_busy = 0;
  int         m_txcyc = 0;
  logic [9:0] m_frame = '1;
  logic [7:0] m_q[$];
  logic       m_ovr = 0;
  logic       m_ferr = 0;
  rxev_t      pend[$];
  rxev_t      ev;
  bit         done;
  bit         rd_pop;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_init = 1;
      m_busy = 0;
      m_q.delete();
      pend.delete();
      m_ovr  = 0;
      m_ferr = 0;
    end else begin
      if (m_busy) begin
        m_txcyc++;
        if (m_txcyc == 10 * CPB) m_busy = 0;
      end else if (uart0_wr) begin
        m_busy  = 1;
        m_txcyc = 0;
        m_frame = {1'b1, uart_w, 1'b0};
      end
      rd_pop = uart0_rd && (m_q.size() > 0);
      done   = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        ev   = pend.pop_front();
        done = 1;
      end
      m_ferr = done && !ev.stop;
      if (rd_pop) void'(m_q.pop_front());
      if (done && ev.stop) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev.b);
        else m_ovr = 1;
      end
      if (uart0_rd) m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("tx", tx, m_busy ? m_frame[m_txcyc / CPB] : 1'b1);
      chk("busy", uart0_busy, m_busy);
      chk("valid", uart0_valid, m_q.size() > 0);
      chk("overrun", uart0_overrun, m_ovr);
      chk("ferr", uart0_ferr, m_ferr);
      if (m_q.size() > 0) chk("data", uart0_data, m_q[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    uart0_wr = 1'b1;
    uart_w   = b;
    tick(1);
    uart0_wr = 1'b0;
  endtask

  task automatic rd();
    uart0_rd = 1'b1;
    tick(1);
    uart0_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxev_t e;
    e.due  = cyc + RX_LAT;
    e.b    = b;
    e.stop = stop;
    pend.push_back(e);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic capture_tx(output logic [9:0] bits, output int busy_n);
    bits   = '0;
    busy_n = 0;
    for (int k = 0; k < 10 * CPB + 10; k++) begin
      if (uart0_busy) busy_n++;
      if (k % CPB == CPB / 2 && k < 10 * CPB) bits[k / CPB] = tx;
      tick(1);
    end
  endtask

  task automatic wait_busy_low(output int t);
    t = 0;
    while (uart0_busy && t < 400) begin
      tick(1);
      t++;
    end
  endtask

  // ---------------- test sequence ----------------
  logic [9:0] bits;
  int         busy_n, t, ferr_n, valid_n, n;

  initial begin
    tick(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", uart0_busy, 1'b0);
    chk("rst_valid", uart0_valid, 1'b0);
    chk("rst_data", uart0_data, 8'h00);
    reset = 1'b0;
    tick(2);

    // 0xA5 frame: start, LSB-first data, stop
    wr(8'hA5);
    capture_tx(bits, busy_n);
    chk("a5_bits", bits, 10'b1101001010);
    chk("a5_busy_cycles", busy_n, 160);

    // write while busy is ignored, back-to-back write right after busy falls
    wr(8'h80);
    tick(30);
    wr(8'hFF);
    wait_busy_low(t);
    chk("b2b_first_len", t, 129);
    wr(8'h7E);
    chk("b2b_busy", uart0_busy, 1'b1);
    chk("b2b_start", tx, 1'b0);
    wait_busy_low(t);
    chk("b2b_second_len", t, 160);
    tick(3);

    // reset during data bit 3
    wr(8'h5A);
    tick(4 * CPB + 5);
    reset = 1'b1;
    tick(1);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", uart0_busy, 1'b0);
    reset = 1'b0;
    tick(2);
    wr(8'h42);
    capture_tx(bits, busy_n);
    chk("x42_byte", bits[8:1], 8'h42);
    chk("x42_start_stop", {bits[9], bits[0]}, 2'b10);
    chk("x42_busy_cycles", busy_n, 160);

    // receive 0x3C and measure latency from the start edge
    fork
      send_frame(8'h3C, 1'b1);
      begin
        t = 0;
        while (!uart0_valid && t < 400) begin
          tick(1);
          t++;
        end
      end
    join
    chk("rx3c_latency", t, 155);
    chk("rx3c_valid", uart0_valid, 1'b1);
    chk("rx3c_data", uart0_data, 8'h3C);
    rd();
    chk("rx3c_popped", uart0_valid, 1'b0);
    rd();
    chk("rd_empty_noeffect", uart0_valid, 1'b0);
    tick(5);

    // false start then framing error
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("false_start", uart0_valid, 1'b0);
    ferr_n  = 0;
    valid_n = 0;
    fork
      send_frame(8'h55, 1'b0);
      for (int k = 0; k < 200; k++) begin
        if (uart0_ferr)  ferr_n++;
        if (uart0_valid) valid_n++;
        tick(1);
      end
    join
    chk("ferr_pulse_len", ferr_n, 1);
    chk("ferr_nothing_stored", valid_n, 0);

    // overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    tick(4);
    chk("ovr_flag", uart0_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("fifo_order", uart0_data, 32'(i));
      rd();
    end
    chk("fifo_drained", uart0_valid, 1'b0);
`else
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    chk("ovr_valid", uart0_valid, 1'b1);
    chk("ovr_kept", uart0_data, 8'h11);
    chk("ovr_flag", uart0_overrun, 1'b1);
    rd();
    chk("ovr_popped", uart0_valid, 1'b0);
`endif
    chk("ovr_cleared", uart0_overrun, 1'b0);

    // pop and store in the same cycle with the buffer full
    for (int i = 0; i < DEPTH; i++) send_frame(8'hA0 + 8'(i), 1'b1);
    fork
      send_frame(8'hBB, 1'b1);
      begin
        tick(RX_LAT - 1);
        uart0_rd = 1'b1;
        tick(1);
        uart0_rd = 1'b0;
      end
    join
    chk("popstore_no_ovr", uart0_overrun, 1'b0);
    n = 0;
    while (uart0_valid && n < 8) begin
      rd();
      n++;
    end
    chk("popstore_count", n, DEPTH);
    tick(5);

    // concurrent random traffic
    fork
      for (int i = 0; i < 8; i++) begin
        wr(8'($urandom));
        tick($urandom_range(5, 200));
      end
      for (int i = 0; i < 8; i++) begin
        send_frame(8'($urandom), $urandom_range(0, 4) != 0);
        tick($urandom_range(2, 30));
      end
      begin
        for (int k = 0; k < 1800; k++) begin
          uart0_rd = ($urandom_range(0, 19) == 0);
          tick(1);
        end
        uart0_rd = 1'b0;
      end
    join
    tick(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_port.md
UART_PORT -- requirements
Module: uart_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 uart0_wr  input  1  one-cycle strobe: transmit byte on uart_w.
REQ-005 uart_w  input  8  byte to transmit; sampled only while uart0_wr=1.
REQ-006 uart0_rd  input  1  one-cycle strobe: consume the byte currently on uart0_data.
REQ-007 uart0_valid  output  1  receive data available.
REQ-008 uart0_data  output  8  oldest received byte; meaningful only while uart0_valid=1.
REQ-009 uart0_busy  output  1  transmitter is sending a frame.
REQ-010 uart0_overrun  output  1  sticky: a received byte was dropped.
REQ-011 uart0_ferr  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 tx  output  1  serial out, idle high.
REQ-013 rx  input  1  serial in, asynchronous, idle high.

Function
REQ-014 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-015 TX states SHALL be IDLE, START, DATA, STOP; uart0_wr in IDLE loads uart_w, enters START, and drives tx=0 from the next cycle.
REQ-016 uart0_busy SHALL be 1 from the cycle after an accepted write until the last STOP cycle ends; frame length is 10*CLKS_PER_BIT cycles.
REQ-017 uart0_wr while uart0_busy=1 SHALL be ignored; the frame in flight is unaffected.
REQ-018 A write in the first cycle after uart0_busy falls SHALL be accepted (back-to-back frames, no extra idle bit).
REQ-019 rx SHALL pass through a two-flop synchroniser before any use.
REQ-020 RX states SHALL be IDLE, START, DATA, STOP; a synchronised 1->0 transition in IDLE enters START.
REQ-021 START SHALL resample at CLKS_PER_BIT/2 (integer division); if high, false start, return to IDLE with nothing stored.
REQ-022 Data and stop bits SHALL be sampled every CLKS_PER_BIT cycles after the start mid-point.
REQ-023 Stop sampled 1: byte SHALL be stored and uart0_valid SHALL be 1 the following cycle.
REQ-024 Stop sampled 0: byte SHALL be discarded, uart0_ferr pulses one cycle, RX waits for rx=1 before returning to IDLE.
REQ-025 uart0_data SHALL be a registered output stable while uart0_valid=1 and not consumed.
REQ-026 uart0_rd with uart0_valid=1 SHALL pop one byte; uart0_valid/uart0_data update the next cycle; uart0_rd with uart0_valid=0 SHALL have no effect.
REQ-027 A byte completing with the buffer full SHALL be dropped and uart0_overrun set; existing contents are kept.
REQ-028 uart0_rd and byte completion in the same cycle with buffer full SHALL pop and store, with no overrun.
REQ-029 uart0_overrun SHALL clear on any uart0_rd or on reset.
REQ-030 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-031 Reset SHALL force tx=1, uart0_busy=0, uart0_valid=0, uart0_data=0, uart0_overrun=0, uart0_ferr=0, both FSMs IDLE, buffer empty, synchroniser to 1.
REQ-032 Reset mid-frame SHALL abort the frame; tx=1 from the cycle after reset is sampled; a partial RX byte is discarded.

Configuration
REQ-033 Macro UART_RX_FIFO_EN defined: receive buffer SHALL be a 4-entry FIFO; full means 4 unread bytes.
REQ-034 UART_RX_FIFO_EN undefined: receive buffer SHALL be a single holding register; full means 1 unread byte.

Verification
REQ-035 CLKS_PER_BIT=16, write 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1 each 16 cycles; uart0_busy high 160 cycles.
REQ-036 Drive rx frame 0x3C -> uart0_valid=1, uart0_data=0x3C one cycle after stop mid-point; uart0_rd -> uart0_valid=0 next cycle.
REQ-037 rx low pulse of 4 cycles -> false start, no uart0_valid; frame 0x55 with stop=0 -> uart0_ferr one-cycle pulse, nothing stored.
REQ-038 No FIFO: frames 0x11 then 0x22 unread -> uart0_data=0x11, uart0_overrun=1; with UART_RX_FIFO_EN, frames 0x01..0x05 unread -> 0x01..0x04 read in order, overrun=1.
REQ-039 uart0_wr 0x80 then uart0_wr 0xFF mid-frame -> only 0x80 sent; write 0x7E in first cycle busy=0 -> second frame starts with no gap.
REQ-040 Reset asserted during TX data bit 3 -> tx=1, uart0_busy=0 the next cycle; subsequent write 0x42 transmits correctly.
